// File: rtl/par_inject_scheduler_pkg.sv
// Shared constants, FSM encoding and helpers for the local injection scheduler.
package par_inject_scheduler_pkg;

    // Flit layout: destination address followed by payload.
    localparam int unsigned PAYLOAD_SIZE = 24;
    localparam int unsigned ADDR_BITS    = 8;
    localparam int unsigned FLIT_DW      = PAYLOAD_SIZE + ADDR_BITS;

    // Width of the delivered-flit statistics counter.
    localparam int unsigned FLIT_CNT_W   = 20;

    typedef enum logic {
        SchedIdle = 1'b0,
        SchedOwn  = 1'b1
    } sched_state_e;

    // Cyclic successor of v in 0..n-1.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/par_inject_scheduler_inj_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after i_ptr, cyclic.
module par_inject_scheduler_inj_rr_pick #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic            o_any,
    output logic [ID_W-1:0] o_sel
);

    int unsigned w_idx;

    // Scan NREQ positions starting at i_ptr; the first hit wins.
    always_comb begin
        o_any = 1'b0;
        o_sel = '0;
        w_idx = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = 32'(i_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!o_any && i_req[w_idx[ID_W-1:0]]) begin
                o_any = 1'b1;
                o_sel = w_idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/par_inject_scheduler.sv
// Weighted round-robin scheduler sharing one router local injection port between
// NREQ requesters, with a registered output stage and a delivered-flit counter.
module par_inject_scheduler
    import par_inject_scheduler_pkg::*;
#(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned DW       = FLIT_DW,
    parameter int unsigned WEIGHT_W = 4,
    parameter int unsigned ID_W     = $clog2(NREQ)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NREQ*DW-1:0]       i_req_data,
    input  logic [NREQ-1:0]          i_req_valid,
    output logic [NREQ-1:0]          o_req_busy,
    input  logic [NREQ*WEIGHT_W-1:0] i_weight,
    output logic [DW-1:0]            o_out_data,
    output logic                     o_out_valid,
    input  logic                     i_out_busy,
    output logic [ID_W-1:0]          o_grant_id,
    output logic [FLIT_CNT_W-1:0]    o_flit_count
);

    sched_state_e          r_state, w_state_next;
    logic [ID_W-1:0]       r_ptr, w_ptr_next;
    logic [ID_W-1:0]       r_owner, w_owner_next;
    logic [WEIGHT_W-1:0]   r_quantum, w_quantum_next;

    logic [DW-1:0]         r_out_data;
    logic                  r_out_valid;
    logic [ID_W-1:0]       r_grant_id;
    logic [FLIT_CNT_W-1:0] r_flit_count;

    logic [DW-1:0]         w_req_data [NREQ];
    logic [WEIGHT_W-1:0]   w_weight [NREQ];
    logic                  w_pick_any;
    logic [ID_W-1:0]       w_pick_sel;
    logic                  w_load;
    logic                  w_grant_now;
    logic [ID_W-1:0]       w_sel;
    logic                  w_accept;
    logic                  w_out_xfer;
    logic [WEIGHT_W-1:0]   w_q_load;

    // Unpack the flat requester buses into per-requester slices.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_req_data[i] = i_req_data[i*DW +: DW];
            w_weight[i]   = i_weight[i*WEIGHT_W +: WEIGHT_W];
        end
    end

    par_inject_scheduler_inj_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .i_req (i_req_valid),
        .i_ptr (r_ptr),
        .o_any (w_pick_any),
        .o_sel (w_pick_sel)
    );

    // Grant decision: the picker in IDLE, the current owner only while in OWN.
    always_comb begin
        w_load      = ~r_out_valid | ~i_out_busy;
        w_out_xfer  = r_out_valid & ~i_out_busy;
        w_sel       = (r_state == SchedOwn) ? r_owner : w_pick_sel;
        w_grant_now = (r_state == SchedOwn) ? i_req_valid[r_owner] : w_pick_any;
        w_accept    = w_load & w_grant_now;
        // A zero weight behaves as a quantum of one flit.
        w_q_load    = (w_weight[w_sel] == '0) ? '0 : w_weight[w_sel] - WEIGHT_W'(1);
    end

    // Only the granted requester is released, and only when the slot can load.
    always_comb begin
        o_req_busy = '1;
        if (!i_reset && w_accept) begin
            o_req_busy[w_sel] = 1'b0;
        end
    end

    // FSM next state, round-robin pointer and quantum bookkeeping.
    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_owner_next   = r_owner;
        w_quantum_next = r_quantum;
        unique case (r_state)
            SchedIdle: begin
                if (w_accept) begin
                    if (w_q_load == '0) begin
                        w_ptr_next = ID_W'(wrap_inc(32'(w_sel), NREQ));
                    end else begin
                        w_state_next   = SchedOwn;
                        w_owner_next   = w_sel;
                        w_quantum_next = w_q_load;
                    end
                end
            end
            SchedOwn: begin
                // Back-pressure freezes everything, including an owner that dropped valid.
                if (w_load) begin
                    if (!i_req_valid[r_owner]) begin
                        w_state_next = SchedIdle;
                        w_ptr_next   = ID_W'(wrap_inc(32'(r_owner), NREQ));
                    end else begin
                        w_quantum_next = r_quantum - WEIGHT_W'(1);
                        if (r_quantum == WEIGHT_W'(1)) begin
                            w_state_next = SchedIdle;
                            w_ptr_next   = ID_W'(wrap_inc(32'(r_owner), NREQ));
                        end
                    end
                end
            end
            default: w_state_next = SchedIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= SchedIdle;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_quantum <= '0;
        end else begin
            r_state   <= w_state_next;
            r_ptr     <= w_ptr_next;
            r_owner   <= w_owner_next;
            r_quantum <= w_quantum_next;
        end
    end

    // Output register: a new flit replaces the draining one; data is kept when emptied.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_grant_id  <= '0;
        end else if (w_accept) begin
            r_out_data  <= w_req_data[w_sel];
            r_out_valid <= 1'b1;
            r_grant_id  <= w_sel;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    // Delivered-flit counter, wraps modulo 2^FLIT_CNT_W.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_flit_count <= '0;
        end else if (w_out_xfer) begin
            r_flit_count <= r_flit_count + FLIT_CNT_W'(1);
        end
    end

    assign o_out_data   = r_out_data;
    assign o_out_valid  = r_out_valid;
    assign o_grant_id   = r_grant_id;
    assign o_flit_count = r_flit_count;

endmodule

// File: tb/tb_par_inject_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized
// run checked every cycle against a burst/credit level model of the scheduler.
module tb_par_inject_scheduler;

    localparam int NREQ     = 3;
    localparam int DW       = 16;
    localparam int WEIGHT_W = 4;
    localparam int ID_W     = 2;
    localparam int CW       = 20;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NREQ*DW-1:0]       req_data;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_busy;
    logic [NREQ*WEIGHT_W-1:0] weight;
    logic [DW-1:0]            out_data;
    logic                     out_valid;
    logic                     out_busy;
    logic [ID_W-1:0]          grant_id;
    logic [CW-1:0]            flit_count;

    int n_checks = 0;
    int n_errors = 0;

    par_inject_scheduler #(
        .NREQ     (NREQ),
        .DW       (DW),
        .WEIGHT_W (WEIGHT_W),
        .ID_W     (ID_W)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req_data   (req_data),
        .i_req_valid  (req_valid),
        .o_req_busy   (req_busy),
        .i_weight     (weight),
        .o_out_data   (out_data),
        .o_out_valid  (out_valid),
        .i_out_busy   (out_busy),
        .o_grant_id   (grant_id),
        .o_flit_count (flit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors < 40) begin
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    // A burst is a run of grants to one owner; credits left counts the flits the owner
    // may still send after the current one.
    logic [DW-1:0]   m_data;
    logic            m_valid;
    int              m_gid;
    int              m_count;
    int              m_ptr;
    int              m_owner;
    int              m_left;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_busy;
        bit              m_load;
        int              cand;
        int              w;
        if (rst) begin
            m_data = '0; m_valid = 1'b0; m_gid = 0; m_count = 0;
            m_ptr = 0; m_owner = 0; m_left = 0;
            chk("rst_busy", 32'(req_busy), 32'(3'b111));
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_count", 32'(flit_count), 32'd0);
        end else begin
            m_load = !m_valid || !out_busy;
            cand = -1;
            if (m_left > 0) begin
                if (req_valid[m_owner]) begin
                    cand = m_owner;
                end else if (m_load) begin
                    m_left = 0;
                    m_ptr = (m_owner + 1) % NREQ;
                end
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    if (cand < 0 && req_valid[(m_ptr + k) % NREQ]) cand = (m_ptr + k) % NREQ;
                end
            end
            exp_busy = '1;
            if (m_load && cand >= 0) exp_busy[cand] = 1'b0;

            chk("m_busy", 32'(req_busy), 32'(exp_busy));
            chk("m_valid", 32'(out_valid), 32'(m_valid));
            chk("m_data", 32'(out_data), 32'(m_data));
            chk("m_gid", 32'(grant_id), 32'(m_gid));
            chk("m_count", 32'(flit_count), 32'(m_count));

            // Effect of the coming rising edge.
            if (m_valid && !out_busy) m_count = (m_count + 1) % (1 << CW);
            if (m_load && cand >= 0) begin
                m_data  = req_data[cand*DW +: DW];
                m_gid   = cand;
                m_valid = 1'b1;
                if (m_left == 0) begin
                    w = int'(weight[cand*WEIGHT_W +: WEIGHT_W]);
                    m_left  = (w == 0 ? 1 : w) - 1;
                    m_owner = cand;
                end else begin
                    m_left = m_left - 1;
                end
                if (m_left == 0) m_ptr = (cand + 1) % NREQ;
            end else if (m_valid && !out_busy) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'($urandom);
    endtask

    task automatic hold_reset(input logic [NREQ-1:0] v);
        rst = 1'b1;
        req_valid = v;
        out_busy = 1'b0;
        step();
        step();
    endtask

    int            exp_seq [9] = '{0, 0, 1, 2, 2, 2, 0, 0, 1};
    logic [DW-1:0] held;
    logic [DW-1:0] want;

    initial begin
        rst = 1'b1;
        req_valid = '0;
        out_busy = 1'b0;
        req_data = '0;
        weight = {4'd3, 4'd1, 4'd2};

        // Reset with everyone requesting, then weighted round-robin {2,1,3}.
        hold_reset(3'b111);
        #2;
        chk("t1_busy_in_reset", 32'(req_busy), 32'(3'b111));
        chk("t1_valid_in_reset", 32'(out_valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            rand_data();
            step();
            chk("t3_grant_seq", 32'(grant_id), 32'(exp_seq[i]));
            chk("t3_no_bubble", 32'(out_valid), 32'd1);
        end

        // Back-pressure in the middle of requester 2's quantum.
        rand_data();
        step();
        chk("t4_grant_first", 32'(grant_id), 32'd2);
        held = out_data;
        out_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            step();
            chk("t4_data_stable", 32'(out_data), 32'(held));
            chk("t4_busy_all", 32'(req_busy), 32'(3'b111));
        end
        out_busy = 1'b0;
        want = req_data[2*DW +: DW];
        step();
        chk("t4_resume_gid", 32'(grant_id), 32'd2);
        chk("t4_resume_data", 32'(out_data), 32'(want));
        rand_data();
        step();
        chk("t4_quantum_last", 32'(grant_id), 32'd2);
        rand_data();
        step();
        chk("t4_next_owner", 32'(grant_id), 32'd0);

        // Single stream, weight 0 behaves as 1.
        weight = {4'd1, 4'd1, 4'd0};
        hold_reset(3'b000);
        rst = 1'b0;
        req_valid = 3'b001;
        for (int i = 0; i < 5; i++) begin
            req_data[0 +: DW] = DW'(16'h11 + i);
            step();
            chk("t2_data", 32'(out_data), 32'(16'h11 + i));
            chk("t2_gid", 32'(grant_id), 32'd0);
        end
        req_valid = 3'b000;
        step();
        chk("t2_count", 32'(flit_count), 32'd5);
        chk("t2_drained", 32'(out_valid), 32'd0);

        // Owner drop costs exactly one bubble.
        weight = {4'd1, 4'd3, 4'd1};
        hold_reset(3'b000);
        rst = 1'b0;
        req_valid = 3'b110;
        rand_data();
        step();
        chk("t5_first_gid", 32'(grant_id), 32'd1);
        req_valid = 3'b100;
        step();
        chk("t5_bubble", 32'(out_valid), 32'd0);
        step();
        chk("t5_next_valid", 32'(out_valid), 32'd1);
        chk("t5_next_gid", 32'(grant_id), 32'd2);

        // Reset asserted while requester 2 owns the port.
        weight = {4'd3, 4'd1, 4'd1};
        hold_reset(3'b000);
        rst = 1'b0;
        req_valid = 3'b100;
        step();
        step();
        chk("t6_pre_count", 32'(flit_count), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_count", 32'(flit_count), 32'd0);
        chk("t6_async_busy", 32'(req_busy), 32'(3'b111));
        step();
        rst = 1'b0;
        req_valid = 3'b111;
        step();
        chk("t6_restart_gid", 32'(grant_id), 32'd0);

        // Randomized epochs, each with its own static weights.
        for (int e = 0; e < 4; e++) begin
            for (int i = 0; i < NREQ; i++) weight[i*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'($urandom_range(0, 5));
            hold_reset(3'b000);
            rst = 1'b0;
            for (int c = 0; c < 1500; c++) begin
                for (int i = 0; i < NREQ; i++) req_valid[i] = ($urandom_range(0, 3) != 0);
                out_busy = ($urandom_range(0, 9) < 3);
                rand_data();
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
